cipher_block_master: RTL and testbench

//  Upstream driver for the 128-bit Avalon-MM encrypt slave. Accepts one plaintext+key block on a

---
 rtl/cipher_block_master.sv | 165 ++++++++++++++++
 tb/tb_cipher_block_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_block_master.sv
// rtl/cipher_block_master.sv - bus master that writes a text/key block to the encrypt slave and reads back the ciphertext
// Optional watchdog: define CBM_TIMEOUT_EN.
module cipher_block_master #(
    parameter int ENC_CYCLES     = 72,
    parameter int READ_LAT       = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         avm_address,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    input  logic         avm_waitrequest,
    output logic         busy,
    output logic         error
);
    localparam int CNT_MAX = (ENC_CYCLES > TIMEOUT_CYCLES) ? ENC_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WAITENC = 3'd2;
    localparam logic [2:0] S_RD      = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    logic [2:0]    r_state;
    logic [255:0]  r_shadow;
    logic [2:0]    r_idx;
    logic          r_gap;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_ridx;
    logic [2:0]    r_rph;
    logic [127:0]  r_out_data;
    logic          r_out_valid;
    logic          r_in_ready;

    logic w_accept;
    logic w_enc_done;
    logic w_timeout;

    assign w_accept   = (r_state == S_IDLE) && in_valid && r_in_ready;
    assign w_enc_done = (r_cnt == CW'(ENC_CYCLES));

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign busy          = (r_state != S_IDLE);
    // Slave FSM is strobe-edge driven, so write is dropped during the gap cycle after each word.
    assign avm_write     = (r_state == S_WR) && !r_gap;
    assign avm_address   = avm_write && (r_idx == 3'd7);
    assign avm_writedata = r_shadow[{r_idx, 5'd0} +: 32];
    assign avm_read      = (r_state == S_RD) && (r_rph == 3'd0);

`ifdef CBM_TIMEOUT_EN
    logic [CW-1:0] r_wdog;
    logic          r_error;
    logic          w_counting;

    assign w_counting = (avm_write && avm_waitrequest) || (r_state == S_WAITENC);
    assign w_timeout  = w_counting && (r_wdog == CW'(TIMEOUT_CYCLES - 1));
    assign error      = r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog  <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_accept)
                r_error <= 1'b0;
            else if (w_timeout)
                r_error <= 1'b1;
            r_wdog <= (w_counting && !w_timeout) ? r_wdog + 1'b1 : '0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shadow    <= '0;
            r_idx       <= '0;
            r_gap       <= 1'b0;
            r_cnt       <= '0;
            r_ridx      <= '0;
            r_rph       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else if (w_timeout) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shadow   <= {in_key, in_text};
                        r_state    <= S_WR;
                        r_idx      <= '0;
                        r_gap      <= 1'b0;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_WR: begin
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else if (!avm_waitrequest) begin
                        if (r_idx == 3'd7) begin
                            r_state <= S_WAITENC;
                            r_cnt   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_gap <= 1'b1;
                        end
                    end
                end
                S_WAITENC: begin
                    if (w_enc_done && !avm_waitrequest) begin
                        r_state <= S_RD;
                        r_ridx  <= '0;
                        r_rph   <= '0;
                    end else if (!w_enc_done) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD: begin
                    // r_rph: 0 strobe, READ_LAT capture, READ_LAT+1 idle before next strobe
                    if (r_rph == 3'(READ_LAT))
                        r_out_data[{r_ridx, 5'd0} +: 32] <= avm_readdata;
                    if (r_rph == 3'(READ_LAT + 1)) begin
                        r_rph <= '0;
                        if (r_ridx == 2'd3) begin
                            r_state     <= S_OUT;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_ridx <= r_ridx + 1'b1;
                        end
                    end else begin
                        r_rph <= r_rph + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cipher_block_master.sv
// tb/tb_cipher_block_master.sv - self-checking bench for cipher_block_master with a behavioural encrypt slave
module tb_cipher_block_master;
    localparam int ENC = 72;
    localparam int RL  = 1;
`ifdef CBM_TIMEOUT_EN
    localparam int TMO = 200;
`else
    localparam int TMO = 1024;
`endif
    localparam logic [127:0] CMAGIC = 128'h5A5A_A5A5_0F1E_2D3C_C3D2_E1F0_1234_8765;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_text = '0;
    logic [127:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         avm_address;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_waitrequest;
    logic         busy;
    logic         error;

    always #5 clk = ~clk;

    cipher_block_master #(.ENC_CYCLES(ENC), .READ_LAT(RL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .error(error)
    );

    // Behavioural encrypt slave: collects eight words, stays busy ENC+extra cycles, serves four reads.
    int          cfg_stall_word = 0;
    int          cfg_stall_len  = 0;
    int          cfg_enc_extra  = 0;
    logic        force_wait     = 1'b0;
    logic [31:0] s_words [8];
    logic [31:0] s_ct [4];
    int          s_wr_count = 0;
    int          s_rd_count = 0;
    int          s_stalls_done = 0;
    int          s_enc_busy = 0;
    int          s_prot_err = 0;
    logic        s_prev_acc = 1'b0;
    logic        s_prev_read = 1'b0;
    logic [127:0] s_magic;

    assign s_magic = CMAGIC;
    assign avm_waitrequest = force_wait || (s_enc_busy != 0) ||
        (avm_write && (s_wr_count == cfg_stall_word) && (s_stalls_done < cfg_stall_len));

    always @(posedge clk) begin
        if (reset) begin
            s_wr_count <= 0; s_rd_count <= 0; s_stalls_done <= 0; s_enc_busy <= 0;
            s_prev_acc <= 1'b0; s_prev_read <= 1'b0; avm_readdata <= '0;
        end else begin
            s_prev_acc  <= avm_write && !avm_waitrequest;
            s_prev_read <= avm_read;
            if ((s_prev_acc && avm_write) || (s_prev_read && avm_read))
                s_prot_err <= s_prot_err + 1;
            if (s_enc_busy != 0)
                s_enc_busy <= s_enc_busy - 1;
            if (avm_write && avm_waitrequest && (s_wr_count == cfg_stall_word) && (s_stalls_done < cfg_stall_len))
                s_stalls_done <= s_stalls_done + 1;
            if (avm_write && !avm_waitrequest) begin
                if (avm_address != (s_wr_count == 7))
                    s_prot_err <= s_prot_err + 1;
                s_words[s_wr_count] <= avm_writedata;
                if (s_wr_count == 7) begin
                    for (int i = 0; i < 4; i++)
                        s_ct[i] <= s_words[i] ^ s_magic[i*32 +: 32] ^
                                   ((((i + 2) % 4) == 3) ? avm_writedata : s_words[4 + ((i + 2) % 4)]);
                    s_wr_count    <= 0;
                    s_stalls_done <= 0;
                    s_rd_count    <= 0;
                    s_enc_busy    <= ENC + cfg_enc_extra;
                end else begin
                    s_wr_count <= s_wr_count + 1;
                end
            end
            if (avm_read) begin
                avm_readdata <= s_ct[s_rd_count];
                s_rd_count   <= (s_rd_count + 1) % 4;
            end else begin
                avm_readdata <= 32'hBAD0_0000 ^ 32'(s_rd_count);
            end
        end
    end

    typedef struct {
        logic [127:0] text;
        logic [127:0] key;
        logic [127:0] exp_ct;
        int stall_word;
        int stall_len;
        int enc_extra;
        int bp;
        int exp_lat;
    } vec_t;

    vec_t vecs [8];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [127:0] ref_ct(input logic [127:0] t, input logic [127:0] k);
        return t ^ {k[63:0], k[127:64]} ^ CMAGIC;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input vec_t v);
        int lat;
        logic [127:0] held;
        cfg_stall_word = v.stall_word;
        cfg_stall_len  = v.stall_len;
        cfg_enc_extra  = v.enc_extra;
        check("in_ready_idle", 128'(in_ready), 128'(1));
        in_valid = 1'b1; in_text = v.text; in_key = v.key;
        tick();
        in_valid = 1'b0; in_text = rnd128(); in_key = rnd128();
        check("accept_state", 128'({busy, in_ready, error}), 128'(3'b100));
        lat = 0;
        while (!out_valid && lat < 3000) begin
            tick();
            lat++;
        end
        check("latency", 128'(lat), 128'(v.exp_lat));
        check("out_data", out_data, v.exp_ct);
        held = out_data;
        for (int i = 0; i < v.bp; i++) begin
            tick();
            check("bp_hold", {out_valid, in_ready, out_data[125:0]}, {1'b1, 1'b0, held[125:0]});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_handshake", 128'({out_valid, in_ready, busy}), 128'(3'b000));
        tick();
        check("in_ready_rise", 128'(in_ready), 128'(1));
        check("bus_protocol", 128'(s_prot_err), 128'(0));
    endtask

    initial begin
        int n;
        logic saw_valid;
        repeat (3) tick();
        check("reset_ctrl", 128'({busy, in_ready, out_valid, avm_write, avm_read, avm_address, error}), 128'(0));
        check("reset_data", out_data, 128'(0));
        reset = 1'b0;
        tick();
        check("ready_after_reset", 128'({in_ready, busy}), 128'(2'b10));

        vecs[0] = '{128'h0, 128'h0, 128'h0, 0, 0, 0, 0, 0};
        vecs[1] = '{128'h0123456789abcdef_fedcba9876543210, 128'h0f0e0d0c0b0a0908_0706050403020100,
                    128'h0, 3, 5, 0, 0, 0};
        vecs[2] = '{rnd128(), rnd128(), 128'h0, 0, 0, 0, 20, 0};
        vecs[3] = '{rnd128(), rnd128(), 128'h0, 0, 0, 30, 0, 0};
        for (int i = 4; i < 8; i++)
            vecs[i] = '{rnd128(), rnd128(), 128'h0, int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                        int'($urandom_range(0, 10)), int'($urandom_range(0, 5)), 0};
        for (int i = 0; i < 8; i++) begin
            vecs[i].exp_ct  = ref_ct(vecs[i].text, vecs[i].key);
            vecs[i].exp_lat = 16 + ENC + 4 * (2 + RL) + vecs[i].stall_len + vecs[i].enc_extra;
        end
        for (int i = 0; i < 8; i++)
            run_block(vecs[i]);

        // Abort a block while it waits for encryption, then run a fresh one.
        in_valid = 1'b1; in_text = rnd128(); in_key = rnd128();
        tick();
        in_valid = 1'b0;
        repeat (40) tick();
        reset = 1'b1;
        tick(); tick();
        check("midreset_ctrl", 128'({busy, in_ready, out_valid, avm_write, avm_read, error}), 128'(0));
        check("midreset_data", out_data, 128'(0));
        reset = 1'b0;
        tick();
        begin
            vec_t v;
            v = '{128'h0123456789ABCDEF0123456789ABCDEF, rnd128(), 128'h0, 0, 0, 0, 0, 0};
            v.exp_ct  = ref_ct(v.text, v.key);
            v.exp_lat = 16 + ENC + 4 * (2 + RL);
            run_block(v);
        end

`ifdef CBM_TIMEOUT_EN
        force_wait = 1'b1;
        cfg_stall_len = 0;
        in_valid = 1'b1; in_text = rnd128(); in_key = rnd128();
        tick();
        in_valid = 1'b0;
        n = 0; saw_valid = 1'b0;
        while (!error && n < 1000) begin
            tick();
            n++;
            if (out_valid) saw_valid = 1'b1;
        end
        check("timeout_cycles", 128'(n), 128'(TMO));
        check("timeout_state", 128'({error, busy, saw_valid}), 128'(3'b100));
        force_wait = 1'b0;
        tick();
        run_block(vecs[0]);
`else
        n = 0; saw_valid = 1'b0;
        force_wait = 1'b1;
        in_valid = 1'b1; in_text = rnd128(); in_key = rnd128();
        tick();
        in_valid = 1'b0;
        while (n < 300) begin
            tick();
            n++;
            if (out_valid || error) saw_valid = 1'b1;
        end
        check("wait_forever", 128'({busy, saw_valid, avm_write}), 128'(3'b101));
        force_wait = 1'b0;
        n = 0;
        while (!out_valid && n < 3000) begin
            tick();
            n++;
        end
        check("wait_release", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
